// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Optional performance counters (cycle_cnt, instret_cnt) are enabled by defining RV_SEQ_PERF_CNT_EN.
module rv32i_multicycle_sequencer #(
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       r_type,
  input  logic       i_type,
  input  logic       load,
  input  logic       store,
  input  logic       branch,
  input  logic       jal,
  input  logic       jalr,
  input  logic       lui,
  input  logic       auipc,
  output logic       imem_req,
  output logic       ir_en,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write_en,
  output logic       pc_en,
  output logic       instr_retired,
  output logic       trap,
  output logic [2:0] state
`ifdef RV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_inc;
  logic [8:0]           class_flags;

  assign class_flags = {r_type, i_type, load, store, branch, jal, jalr, lui, auipc};
  assign wait_inc    = wait_cnt + TIMEOUT_W'(1);
  assign state       = state_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state_q == S_EXEC) begin
      wait_cnt <= '0;
    end else if (state_q == S_MEM && !dmem_ack) begin
      wait_cnt <= wait_inc;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = $onehot(class_flags) ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (load | store) ? S_MEM : S_WB;
      // Ack wins over the timeout when both land in the same cycle.
      S_MEM: begin
        if (dmem_ack)          state_d = S_WB;
        else if (&wait_inc)    state_d = S_TRAP;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    ir_en         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write_en  = 1'b0;
    pc_en         = 1'b0;
    instr_retired = 1'b0;
    trap          = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store;
      end
      S_WB: begin
        reg_write_en  = r_type | i_type | load | jal | jalr | lui | auipc;
        pc_en         = 1'b1;
        instr_retired = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

`ifdef RV_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_retired) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/rv32i_multicycle_sequencer.md
Name: rv32i_multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the RV32I core.
- Consumes the one-hot instruction-class flags produced by the control decoder and steps the datapath through IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Generates memory request handshakes and gated enables for the PC, IR and register file.
- Reports illegal instructions and memory timeouts through a sticky trap.

Parameters:
- TIMEOUT_W, 4: width of the MEM-state wait counter; timeout fires when the counter equals 2^TIMEOUT_W-1 (15 by default).

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-low reset
- run  input  1  level enable; sequencer leaves IDLE only while high
- imem_ack  input  1  instruction memory data valid this cycle
- dmem_ack  input  1  data memory access complete this cycle
- r_type, i_type, load, store, branch, jal, jalr, lui, auipc  input  1 each  decoded instruction class flags, valid in DECODE/EXEC/MEM/WB
- imem_req  output  1  instruction fetch request
- ir_en  output  1  instruction register load strobe
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (store)
- reg_write_en  output  1  register file write strobe
- pc_en  output  1  PC update strobe
- instr_retired  output  1  one-cycle pulse per completed instruction
- trap  output  1  sticky fault flag
- state  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, trap=0. All outputs are 0 while in reset.
- Outputs are Moore-decoded from state, except ir_en = (state==FETCH) & imem_ack, and the MEM exit handled below.
- IDLE: outputs 0. If run=1, go to FETCH next cycle.
- FETCH: imem_req=1. When imem_ack=1, ir_en=1 and go to DECODE. Otherwise hold; there is no fetch timeout.
- DECODE: one cycle. Count the class flags set:
  - exactly one set: go to EXEC;
  - zero or more than one set: go to TRAP.
- EXEC: one cycle. If load|store, clear the wait counter and go to MEM; else go to WB.
- MEM: dmem_req=1, dmem_we=store.
  - dmem_ack=1: go to WB.
  - Otherwise the counter increments; at all-ones with no ack, go to TRAP.
  - If ack arrives in the same cycle the counter reaches all-ones, ack wins and the next state is WB.
- WB: one cycle.
  - reg_write_en = r_type|i_type|load|jal|jalr|lui|auipc. It is 0 for store and branch.
  - pc_en=1 and instr_retired=1.
  - Next state is FETCH if run=1, else IDLE.
- TRAP: trap=1, all other outputs 0. Held until reset; run is ignored.
- run deasserted mid-instruction does not abort; the instruction completes and the sequencer parks in IDLE after WB.
- Latency with zero-wait memories (ack in the first request cycle):
  - non-memory instruction: 4 cycles, FETCH to WB inclusive;
  - load/store: 5 cycles.
  - Each wait cycle adds 1.
- Reset asserted in any state, including mid-MEM with dmem_req=1, drops all requests in the same cycle, asynchronously.
- State register and counter change only on the rising clk edge, except on reset.

Optional Feature:
- Macro: RV_SEQ_PERF_CNT_EN.
- Defined:
  - adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0;
  - cycle_cnt increments every cycle state!=IDLE and state!=TRAP;
  - instret_cnt increments on instr_retired;
  - both wrap 0xFFFFFFFF to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Reset, then run=1, r_type=1, imem_ack=1 constant -> state sequence 0,1,2,3,5,1; reg_write_en=1 and pc_en=1 only in WB; instr_retired pulses every 4 cycles.
2. load=1, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_write_en=1 in WB; store=1 with the same delay -> dmem_we=1 during MEM, reg_write_en=0 in WB.
3. store=1, dmem_ack never asserted, TIMEOUT_W=4 -> state=6 after 15 MEM cycles, trap=1 and held; run toggling has no effect until rst=0.
4. Flags all 0, then separately branch=1 with jal=1 -> TRAP entered from DECODE, no pc_en pulse.
5. rst pulsed low mid-MEM with dmem_req=1 -> dmem_req=0 immediately, state=0, trap=0; on release with run=0 the sequencer stays IDLE.
6. With RV_SEQ_PERF_CNT_EN defined, run 10 back-to-back r_type instructions with zero wait -> instret_cnt=10, cycle_cnt=40; preload cycle_cnt to 0xFFFFFFFF via force, one active cycle -> 0.
